// File: rtl/gcd_ctrl.sv
// gcd_ctrl: control FSM for a subtractive 32-bit GCD datapath.
// It sequences the operand load, then one subtract step per cycle, then the
// result load. A run that does not converge within MAX_ITER steps is aborted
// and flagged.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   start      run request, accepted only while ready
//   a_gt_b     datapath comparator flag, A > B
//   a_eq_b     datapath comparator flag, A == B
//   a_lt_b     datapath comparator flag, A < B
//   a_sel      A mux select: 1 = in1, 0 = A-B
//   b_sel      B mux select: 1 = in2, 0 = B-A
//   a_ld       A register load enable
//   b_ld       B register load enable
//   output_en  result register load enable
//   ready      idle, start accepted this cycle
//   busy       run in progress
//   done       one-cycle completion pulse, on success and on error
//   err        last run aborted, held until the next accepted start
//   iter_count subtract steps taken in the current or last run
module gcd_ctrl #(
    parameter int unsigned      CNT_W    = 16,
    parameter logic [CNT_W-1:0] MAX_ITER = CNT_W'(16'hFFFF)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             a_gt_b,
    input  logic             a_eq_b,
    input  logic             a_lt_b,
    output logic             a_sel,
    output logic             b_sel,
    output logic             a_ld,
    output logic             b_ld,
    output logic             output_en,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] iter_count
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_CHECK = 3'd2,
        S_OUT   = 3'd3,
        S_FIN   = 3'd4,
        S_ERR   = 3'd5
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] iter_q, iter_d;
    logic             err_q, err_d;

    // CHECK decision terms, shared by next-state and output decode
    logic flags_ok;
    logic at_limit;
    logic step_c;

    assign flags_ok = $onehot({a_gt_b, a_eq_b, a_lt_b});
    assign at_limit = (iter_q == MAX_ITER);
    // A subtract step happens only when no earlier priority term applies
    assign step_c   = (state_q == S_CHECK) && flags_ok && !a_eq_b && !at_limit;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                state_d = S_CHECK;
            end
            S_CHECK: begin
                // Illegal flags beat equality, equality beats the limit
                if (!flags_ok) begin
                    state_d = S_ERR;
                end else if (a_eq_b) begin
                    state_d = S_OUT;
                end else if (at_limit) begin
                    state_d = S_ERR;
                end
            end
            S_OUT:   state_d = S_FIN;
            S_FIN:   state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode: Moore terms per state, Mealy load strobes in CHECK
    always_comb begin
        a_sel     = 1'b0;
        b_sel     = 1'b0;
        a_ld      = 1'b0;
        b_ld      = 1'b0;
        output_en = 1'b0;
        done      = 1'b0;
        ready     = (state_q == S_IDLE);
        busy      = (state_q != S_IDLE);
        case (state_q)
            S_LOAD: begin
                a_sel = 1'b1;
                b_sel = 1'b1;
                a_ld  = 1'b1;
                b_ld  = 1'b1;
            end
            S_CHECK: begin
                // Mux selects stay 0 so the loaded value is the difference
                if (step_c) begin
                    a_ld = a_gt_b;
                    b_ld = a_lt_b;
                end
            end
            S_OUT: begin
                output_en = 1'b1;
            end
            S_FIN, S_ERR: begin
                done = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Iteration counter and sticky error flag
    always_comb begin
        iter_d = iter_q;
        err_d  = err_q;
        if (state_q == S_LOAD) begin
            iter_d = '0;
        end else if (step_c) begin
            // step_c excludes iter_q == MAX_ITER, so this cannot pass the limit
            iter_d = iter_q + CNT_W'(1);
        end
        if ((state_q == S_IDLE) && start) begin
            err_d = 1'b0;
        end else if (state_d == S_ERR) begin
            // Set on entry so err is visible together with done
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            iter_q <= '0;
            err_q  <= 1'b0;
        end else begin
            iter_q <= iter_d;
            err_q  <= err_d;
        end
    end

    assign err        = err_q;
    assign iter_count = iter_q;

endmodule
